// File: rtl/operand_fwd_unit_if.sv
// Operand-forwarding bus: decode-side request, producer forwarding
// network, downstream control and the registered EX operand.
interface operand_fwd_unit_if #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
);
  localparam int SELW = $clog2(NSRC + 1);

  logic                   id_valid;
  logic [RADDR-1:0]       rs_addr;
  logic [WIDTH-1:0]       rf_data;
  logic [NSRC-1:0]        src_valid;
  logic [NSRC-1:0]        src_ready;
  logic [NSRC*RADDR-1:0]  src_waddr;
  logic [NSRC*WIDTH-1:0]  src_wdata;
  logic                   stall_in;
  logic                   flush;
  logic [WIDTH-1:0]       op_data;
  logic                   op_valid;
  logic [SELW-1:0]        fwd_sel;
  logic                   hazard_stall;
  logic [CNTW-1:0]        hazard_cnt;

  // Pipeline side: drives the request and producer state, observes the operand.
  modport master (
    output id_valid, rs_addr, rf_data, src_valid, src_ready, src_waddr,
           src_wdata, stall_in, flush,
    input  op_data, op_valid, fwd_sel, hazard_stall, hazard_cnt
  );

  // Forwarding unit side.
  modport slave (
    input  id_valid, rs_addr, rf_data, src_valid, src_ready, src_waddr,
           src_wdata, stall_in, flush,
    output op_data, op_valid, fwd_sel, hazard_stall, hazard_cnt
  );
endinterface

// File: rtl/operand_fwd_unit.sv
// Operand forwarding stage: picks the youngest matching in-flight producer
// (or the register file), raises a load-use stall when that producer is not
// ready, and registers the operand into the EX-input register.
module operand_fwd_unit #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 3,
  parameter int RADDR = 5,
  parameter int CNTW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  operand_fwd_unit_if.slave  bus
);
  localparam int SELW = $clog2(NSRC + 1);

  logic [WIDTH-1:0] w_data;
  logic [SELW-1:0]  w_sel;
  logic             w_hit;
  logic             w_win_ready;
  logic             w_hazard;

  logic [WIDTH-1:0] r_op_data;
  logic             r_op_valid;
  logic [SELW-1:0]  r_fwd_sel;
  logic [CNTW-1:0]  r_hazard_cnt;

  // Source select: youngest matching producer wins, r0 always reads as zero.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    w_data      = bus.rf_data;
    w_sel       = '0;
    w_hit       = 1'b0;
    w_win_ready = 1'b1;
    if (bus.rs_addr == '0) begin
      w_data = '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (!w_hit && bus.src_valid[i] &&
            (bus.src_waddr[i*RADDR +: RADDR] == bus.rs_addr)) begin
          w_hit       = 1'b1;
          w_sel       = SELW'(i + 1);
          w_data      = bus.src_wdata[i*WIDTH +: WIDTH];
          w_win_ready = bus.src_ready[i];
        end
      end
    end
  end

  // The winning producer is the only legal source; an unready winner stalls.
  assign w_hazard = bus.id_valid & w_hit & ~w_win_ready;

  // EX-input register: flush beats stall, stall beats advance; bubbles are zeroed.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      r_op_data  <= '0;
      r_op_valid <= 1'b0;
      r_fwd_sel  <= '0;
    end else if (bus.flush) begin
      r_op_data  <= '0;
      r_op_valid <= 1'b0;
      r_fwd_sel  <= '0;
    end else if (!bus.stall_in) begin
      if (bus.id_valid && !w_hazard) begin
        r_op_data  <= w_data;
        r_op_valid <= 1'b1;
        r_fwd_sel  <= w_sel;
      end else begin
        r_op_data  <= '0;
        r_op_valid <= 1'b0;
        r_fwd_sel  <= '0;
      end
    end
  end

  // Saturating count of stall cycles, unaffected by downstream stall or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hazard_cnt <= '0;
    end else if (w_hazard && (r_hazard_cnt != '1)) begin
      r_hazard_cnt <= r_hazard_cnt + 1'b1;
    end
  end

  assign bus.op_data      = r_op_data;
  assign bus.op_valid     = r_op_valid;
  assign bus.fwd_sel      = r_fwd_sel;
  assign bus.hazard_stall = w_hazard;
  assign bus.hazard_cnt   = r_hazard_cnt;
endmodule

// File: tb/tb_operand_fwd_unit.sv
// Randomized and directed bench for operand_fwd_unit. Three instances share
// one stimulus: (NSRC=3, CNTW=16), (NSRC=1, CNTW=4), (NSRC=5, CNTW=4); each
// uses the low NSRC producer slices. A behavioural model predicts every output.
module tb_operand_fwd_unit;
  localparam int NI = 3;
  localparam int NS_A [NI] = '{3, 1, 5};
  localparam int CW_A [NI] = '{16, 4, 4};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        id_valid;
  logic [4:0]  rs_addr;
  logic [31:0] rf_data;
  logic [4:0]  s_valid;
  logic [4:0]  s_ready;
  logic [24:0] s_waddr;
  logic [159:0] s_wdata;
  logic        stall_in;
  logic        flush;

  logic [31:0] obs_data  [NI];
  logic        obs_valid [NI];
  logic [2:0]  obs_sel   [NI];
  logic        obs_haz   [NI];
  logic [15:0] obs_cnt   [NI];

  int n_total = 0;
  int n_bad   = 0;

  // Model state per instance.
  logic [31:0] m_data  [NI];
  logic        m_valid [NI];
  int          m_sel   [NI];
  int          m_cnt   [NI];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int NS = NS_A[k];
    localparam int CW = CW_A[k];
    operand_fwd_unit_if #(.WIDTH(32), .NSRC(NS), .RADDR(5), .CNTW(CW)) u_if ();
    assign u_if.id_valid  = id_valid;
    assign u_if.rs_addr   = rs_addr;
    assign u_if.rf_data   = rf_data;
    assign u_if.src_valid = s_valid[NS-1:0];
    assign u_if.src_ready = s_ready[NS-1:0];
    assign u_if.src_waddr = s_waddr[NS*5-1:0];
    assign u_if.src_wdata = s_wdata[NS*32-1:0];
    assign u_if.stall_in  = stall_in;
    assign u_if.flush     = flush;
    assign obs_data[k]  = u_if.op_data;
    assign obs_valid[k] = u_if.op_valid;
    assign obs_sel[k]   = 3'(u_if.fwd_sel);
    assign obs_haz[k]   = u_if.hazard_stall;
    assign obs_cnt[k]   = 16'(u_if.hazard_cnt);
    operand_fwd_unit #(.WIDTH(32), .NSRC(NS), .RADDR(5), .CNTW(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
    );
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference selection from the rules: collect all matching producers
  // oldest-last, the head of the list is the youngest and the only candidate.
  function automatic void model_sel(input int ns, output logic [31:0] d,
                                    output int sel, output logic haz);
    int q[$];
    for (int i = 0; i < ns; i++)
      if (s_valid[i] && s_waddr[i*5 +: 5] == rs_addr) q.push_back(i);
    haz = 1'b0;
    if (rs_addr == 5'd0) begin
      d = 32'd0; sel = 0;
    end else if (q.size() == 0) begin
      d = rf_data; sel = 0;
    end else begin
      d   = s_wdata[q[0]*32 +: 32];
      sel = q[0] + 1;
      haz = id_valid && !s_ready[q[0]];
    end
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NI; k++) begin
      m_data[k] = '0; m_valid[k] = 1'b0; m_sel[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; rs_addr = 0; rf_data = 0; s_valid = 0; s_ready = '1;
    s_waddr = 0; s_wdata = 0; stall_in = 0; flush = 0;
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s_valid%0d", tag, k), obs_valid[k], m_valid[k]);
      check($sformatf("%s_data%0d", tag, k), obs_data[k], m_data[k]);
      check($sformatf("%s_sel%0d", tag, k), obs_sel[k], m_sel[k]);
      check($sformatf("%s_cnt%0d", tag, k), obs_cnt[k], m_cnt[k]);
    end
  endtask

  // One clock: check the combinational stall, step the model, check registers.
  task automatic cycle();
    logic [31:0] ed [NI];
    int          es [NI];
    logic        eh [NI];
    #1;
    for (int k = 0; k < NI; k++) begin
      model_sel(NS_A[k], ed[k], es[k], eh[k]);
      check($sformatf("haz%0d", k), obs_haz[k], eh[k]);
    end
    @(posedge clk);
    for (int k = 0; k < NI; k++) begin
      if (eh[k] && m_cnt[k] < (1 << CW_A[k]) - 1) m_cnt[k]++;
      if (flush) begin
        m_valid[k] = 0; m_data[k] = 0; m_sel[k] = 0;
      end else if (!stall_in) begin
        m_valid[k] = id_valid && !eh[k];
        m_data[k]  = m_valid[k] ? ed[k] : 32'd0;
        m_sel[k]   = m_valid[k] ? es[k] : 0;
      end
    end
    #1;
    check_regs("reg");
  endtask

  // Async reset asserted between edges; outputs must clear before any clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_regs("rst");
    #2 rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    model_clear();
    #1;
    check_regs("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Build hazard_cnt=5 with op_valid=1, then reset mid-run.
    id_valid = 1; rs_addr = 7; s_valid = 5'b00001; s_waddr[4:0] = 7;
    s_ready = 5'b00000; s_wdata[31:0] = 32'h77;
    repeat (5) cycle();
    s_ready = '1;
    cycle();
    check("t1_cnt5", obs_cnt[0], 5);
    check("t1_valid", obs_valid[0], 1);
    do_reset();
    check("t1_rst_cnt", obs_cnt[0], 0);

    // Youngest of two matching producers wins.
    clear_inputs();
    id_valid = 1; rs_addr = 7; rf_data = 32'h11; s_valid = 5'b00101;
    s_waddr[4:0] = 7; s_waddr[14:10] = 7;
    s_wdata[31:0] = 32'hAA; s_wdata[95:64] = 32'hCC;
    cycle();
    check("t2_data", obs_data[0], 32'hAA);
    check("t2_sel", obs_sel[0], 1);

    // Unready youngest producer stalls even though an older one is ready.
    clear_inputs();
    id_valid = 1; rs_addr = 7; s_valid = 5'b00011;
    s_waddr[4:0] = 7; s_waddr[9:5] = 7; s_ready = 5'b00010;
    s_wdata[63:32] = 32'hBB;
    cycle();
    check("t3_valid", obs_valid[0], 0);
    s_ready = 5'b00011; s_wdata[31:0] = 32'h55;
    cycle();
    check("t3_data", obs_data[0], 32'h55);

    // r0 reads as zero even with a producer targeting it.
    clear_inputs();
    id_valid = 1; rs_addr = 0; rf_data = 32'h99; s_valid = 5'b00001;
    s_wdata[31:0] = 32'hFF;
    cycle();
    check("t4_data", obs_data[0], 0);
    check("t4_valid", obs_valid[0], 1);

    // Stall holds the captured operand; flush during stall kills it.
    clear_inputs();
    id_valid = 1; rs_addr = 7; s_valid = 5'b00010; s_waddr[9:5] = 7;
    s_wdata[63:32] = 32'h1234;
    cycle();
    stall_in = 1; s_wdata[63:32] = 32'h9999;
    repeat (3) cycle();
    check("t5_hold", obs_data[0], 32'h1234);
    flush = 1;
    cycle();
    check("t5_flush", obs_valid[0], 0);

    // Saturation of the 4-bit counters.
    clear_inputs();
    do_reset();
    id_valid = 1; rs_addr = 7; s_valid = 5'b00001; s_waddr[4:0] = 7;
    s_ready = 5'b00000;
    repeat (20) cycle();
    check("t6_sat_n1", obs_cnt[1], 15);
    check("t6_sat_n5", obs_cnt[2], 15);
    check("t6_n3", obs_cnt[0], 20);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      rs_addr  = 5'($urandom_range(0, 3));
      rf_data  = $urandom;
      s_valid  = 5'($urandom);
      for (int i = 0; i < 5; i++) begin
        s_ready[i]         = ($urandom_range(0, 3) != 0);
        s_waddr[i*5 +: 5]  = 5'($urandom_range(0, 3));
        s_wdata[i*32 +: 32] = $urandom;
      end
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      cycle();
      if (n % 700 == 699) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
